regfile_writeback_arbiter: RTL and testbench



---
 rtl/regfile_writeback_arbiter.sv | 164 ++++++++++++++++
 tb/tb_regfile_writeback_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter: buffers core 0/1 results and drives the register file's two write ports.
// Optional WB_COLLISION_STATS_EN adds a saturating same-address collision counter.
module regfile_writeback_arbiter #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 128
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in0_valid,
   output logic              in0_ready,
   input  logic [ADDR_W-1:0] in0_addr,
   input  logic [DATA_W-1:0] in0_data,
   input  logic              in1_valid,
   output logic              in1_ready,
   input  logic [ADDR_W-1:0] in1_addr,
   input  logic [DATA_W-1:0] in1_data,
   output logic              write_signal_1,
   output logic [ADDR_W-1:0] write_addr_1,
   output logic [DATA_W-1:0] data_write_1,
   output logic              write_signal_2,
   output logic [ADDR_W-1:0] write_addr_2,
   output logic [DATA_W-1:0] data_write_2,
`ifdef WB_COLLISION_STATS_EN
   output logic [15:0]       collision_count,
`endif
   output logic              idle
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [ADDR_W-1:0] fifo0_addr_q [DEPTH];
   logic [DATA_W-1:0] fifo0_data_q [DEPTH];
   logic [ADDR_W-1:0] fifo1_addr_q [DEPTH];
   logic [DATA_W-1:0] fifo1_data_q [DEPTH];

   logic [PTR_W-1:0] wr0_q, rd0_q, wr1_q, rd1_q;
   logic [CNT_W-1:0] count0_q, count0_d, count1_q, count1_d;
   logic             prio_q, prio_d;

   logic              ws1_q, ws2_q;
   logic [ADDR_W-1:0] addr1_q, addr2_q;
   logic [DATA_W-1:0] data1_q, data2_q;

   logic              push0, push1, pop0, pop1, collision;
   logic              head0_valid, head1_valid;
   logic [ADDR_W-1:0] head0_addr, head1_addr;
   logic [DATA_W-1:0] head0_data, head1_data;

   assign in0_ready = (count0_q != FULL);
   assign in1_ready = (count1_q != FULL);

   // Pinned registers 0 and 20 complete the handshake but are never queued
   assign push0 = in0_valid && in0_ready &&
                  (in0_addr != ADDR_W'(0)) && (in0_addr != ADDR_W'(20));
   assign push1 = in1_valid && in1_ready &&
                  (in1_addr != ADDR_W'(0)) && (in1_addr != ADDR_W'(20));

   assign head0_valid = (count0_q != '0);
   assign head1_valid = (count1_q != '0);
   assign head0_addr  = fifo0_addr_q[rd0_q];
   assign head0_data  = fifo0_data_q[rd0_q];
   assign head1_addr  = fifo1_addr_q[rd1_q];
   assign head1_data  = fifo1_data_q[rd1_q];

   always_comb begin
      pop0      = 1'b0;
      pop1      = 1'b0;
      collision = 1'b0;
      prio_d    = prio_q;
      if (head0_valid && head1_valid && (head0_addr == head1_addr)) begin
         // Same target: priority core writes first, the other follows next cycle
         collision = 1'b1;
         if (!prio_q) begin
            pop0 = 1'b1;
         end else begin
            pop1 = 1'b1;
         end
         prio_d = ~prio_q;
      end else begin
         pop0 = head0_valid;
         pop1 = head1_valid;
      end
   end

   always_comb begin
      count0_d = count0_q + CNT_W'(push0) - CNT_W'(pop0);
      count1_d = count1_q + CNT_W'(push1) - CNT_W'(pop1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr0_q    <= '0;
         rd0_q    <= '0;
         wr1_q    <= '0;
         rd1_q    <= '0;
         count0_q <= '0;
         count1_q <= '0;
         prio_q   <= 1'b0;
         ws1_q    <= 1'b0;
         ws2_q    <= 1'b0;
         addr1_q  <= '0;
         addr2_q  <= '0;
         data1_q  <= '0;
         data2_q  <= '0;
      end else begin
         count0_q <= count0_d;
         count1_q <= count1_d;
         prio_q   <= prio_d;
         ws1_q    <= pop0;
         ws2_q    <= pop1;
         if (push0) wr0_q <= wr0_q + PTR_W'(1);
         if (push1) wr1_q <= wr1_q + PTR_W'(1);
         if (pop0) begin
            rd0_q   <= rd0_q + PTR_W'(1);
            addr1_q <= head0_addr;
            data1_q <= head0_data;
         end
         if (pop1) begin
            rd1_q   <= rd1_q + PTR_W'(1);
            addr2_q <= head1_addr;
            data2_q <= head1_data;
         end
      end
   end

   // Storage needs no reset: validity is tracked by the counts
   always_ff @(posedge clk) begin
      if (push0) begin
         fifo0_addr_q[wr0_q] <= in0_addr;
         fifo0_data_q[wr0_q] <= in0_data;
      end
      if (push1) begin
         fifo1_addr_q[wr1_q] <= in1_addr;
         fifo1_data_q[wr1_q] <= in1_data;
      end
   end

`ifdef WB_COLLISION_STATS_EN
   logic [15:0] coll_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         coll_cnt_q <= '0;
      end else if (collision && (coll_cnt_q != 16'hFFFF)) begin
         coll_cnt_q <= coll_cnt_q + 16'd1;
      end
   end

   assign collision_count = coll_cnt_q;
`endif

   assign write_signal_1 = ws1_q;
   assign write_addr_1   = addr1_q;
   assign data_write_1   = data1_q;
   assign write_signal_2 = ws2_q;
   assign write_addr_2   = addr2_q;
   assign data_write_2   = data2_q;

   assign idle = (count0_q == '0) && (count1_q == '0) && !ws1_q && !ws2_q;

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Scoreboard bench for regfile_writeback_arbiter: per-port expected-write queues plus directed timing checks.
module tb_regfile_writeback_arbiter;

   logic         clk;
   logic         reset;
   logic         in0_valid, in0_ready, in1_valid, in1_ready;
   logic [6:0]   in0_addr, in1_addr;
   logic [127:0] in0_data, in1_data;
   logic         write_signal_1, write_signal_2, idle;
   logic [6:0]   write_addr_1, write_addr_2;
   logic [127:0] data_write_1, data_write_2;
`ifdef WB_COLLISION_STATS_EN
   logic [15:0]  collision_count;
`endif

   regfile_writeback_arbiter #(.DEPTH(4), .ADDR_W(7), .DATA_W(128)) dut (
      .clk            (clk),
      .reset          (reset),
      .in0_valid      (in0_valid),
      .in0_ready      (in0_ready),
      .in0_addr       (in0_addr),
      .in0_data       (in0_data),
      .in1_valid      (in1_valid),
      .in1_ready      (in1_ready),
      .in1_addr       (in1_addr),
      .in1_data       (in1_data),
      .write_signal_1 (write_signal_1),
      .write_addr_1   (write_addr_1),
      .data_write_1   (data_write_1),
      .write_signal_2 (write_signal_2),
      .write_addr_2   (write_addr_2),
      .data_write_2   (data_write_2),
`ifdef WB_COLLISION_STATS_EN
      .collision_count(collision_count),
`endif
      .idle           (idle)
   );

   typedef struct {
      logic [6:0]   addr;
      logic [127:0] data;
   } entry_t;

   entry_t exp0[$];
   entry_t exp1[$];
   entry_t m0, m1;
   int     errors = 0;
   int     checks = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive one beat at negedge, note handshakes, return at posedge+1
   task automatic drive(input logic v0, input logic [6:0] a0, input logic [127:0] d0,
                        input logic v1, input logic [6:0] a1, input logic [127:0] d1,
                        output logic acc0, output logic acc1);
      entry_t e;
      @(negedge clk);
      in0_valid = v0; in0_addr = a0; in0_data = d0;
      in1_valid = v1; in1_addr = a1; in1_data = d1;
      acc0 = v0 && in0_ready;
      acc1 = v1 && in1_ready;
      if (acc0 && a0 != 7'd0 && a0 != 7'd20) begin
         e.addr = a0; e.data = d0; exp0.push_back(e);
      end
      if (acc1 && a1 != 7'd0 && a1 != 7'd20) begin
         e.addr = a1; e.data = d1; exp1.push_back(e);
      end
      @(posedge clk); #1;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      exp0.delete();
      exp1.delete();
      @(posedge clk); #1;
      check_eq("rst_ws1", write_signal_1, 0);
      check_eq("rst_ws2", write_signal_2, 0);
      check_eq("rst_in0_ready", in0_ready, 1);
      check_eq("rst_idle", idle, 1);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Scoreboard: every issued write must match the oldest expected entry of its core
   always @(posedge clk) begin
      #1;
      if (!reset) begin
         if (write_signal_1) begin
            check_eq("wr1_expected", exp0.size() != 0, 1);
            if (exp0.size() != 0) begin
               m0 = exp0.pop_front();
               check_eq("wr1_addr", write_addr_1, m0.addr);
               check_eq("wr1_data", data_write_1, m0.data);
            end
         end
         if (write_signal_2) begin
            check_eq("wr2_expected", exp1.size() != 0, 1);
            if (exp1.size() != 0) begin
               m1 = exp1.pop_front();
               check_eq("wr2_addr", write_addr_2, m1.addr);
               check_eq("wr2_data", data_write_2, m1.data);
            end
         end
         if (write_signal_1 && write_signal_2)
            check_eq("dual_addr_differs", write_addr_1 != write_addr_2, 1);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic a0, a1, saw_full;
      int   sent0, sent1, k;

      reset = 1'b1;
      in0_valid = 1'b0; in0_addr = '0; in0_data = '0;
      in1_valid = 1'b0; in1_addr = '0; in1_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("init_ws1", write_signal_1, 0);
      check_eq("init_addr1", write_addr_1, 0);
      check_eq("init_data1", data_write_1, 0);
      check_eq("init_ws2", write_signal_2, 0);
      check_eq("init_in0_ready", in0_ready, 1);
      check_eq("init_in1_ready", in1_ready, 1);
      check_eq("init_idle", idle, 1);
      @(negedge clk);
      reset = 1'b0;

      // Single beat: write appears one cycle after accept
      drive(1, 7'd5, 128'hA, 0, 7'd0, 128'h0, a0, a1);
      check_eq("t1_accept", a0, 1);
      check_eq("t1_not_early", write_signal_1, 0);
      @(posedge clk); #1;
      check_eq("t1_ws1", write_signal_1, 1);
      check_eq("t1_addr1", write_addr_1, 5);
      check_eq("t1_data1", data_write_1, 128'hA);
      check_eq("t1_ws2", write_signal_2, 0);

      // Both cores, distinct addresses: both ports in one cycle
      drive(1, 7'd3, 128'h11, 1, 7'd4, 128'h22, a0, a1);
      @(posedge clk); #1;
      check_eq("t2_ws1", write_signal_1, 1);
      check_eq("t2_ws2", write_signal_2, 1);
      check_eq("t2_addr1", write_addr_1, 3);
      check_eq("t2_addr2", write_addr_2, 4);

      // Same address: core 0 first, core 1 next cycle
      do_reset();
      drive(1, 7'd9, 128'h1, 1, 7'd9, 128'h2, a0, a1);
      @(posedge clk); #1;
      check_eq("t3_c1_ws1", write_signal_1, 1);
      check_eq("t3_c1_data1", data_write_1, 128'h1);
      check_eq("t3_c1_ws2", write_signal_2, 0);
      @(posedge clk); #1;
      check_eq("t3_c2_ws1", write_signal_1, 0);
      check_eq("t3_c2_ws2", write_signal_2, 1);
      check_eq("t3_c2_addr2", write_addr_2, 9);
      check_eq("t3_c2_data2", data_write_2, 128'h2);
      check_eq("t3_addr1_hold", write_addr_1, 9);
`ifdef WB_COLLISION_STATS_EN
      check_eq("t3_coll_count", collision_count, 1);
`endif

      // Colliding streams: core 0 drains at half rate and must fill
      sent0 = 0; sent1 = 0; saw_full = 1'b0;
      for (int c = 0; c < 100 && (sent0 < 12 || sent1 < 12); c++) begin
         drive(sent0 < 12, 7'd7, 128'(sent0 + 32'h100),
               sent1 < 12, 7'd7, 128'(sent1 + 32'h200), a0, a1);
         if (sent0 < 12 && !a0) saw_full = 1'b1;
         sent0 += int'(a0);
         sent1 += int'(a1);
      end
      check_eq("t4_sent0", sent0, 12);
      check_eq("t4_sent1", sent1, 12);
      check_eq("t4_in0_full_seen", saw_full, 1);
      k = 0;
      while (!idle && k < 60) begin
         @(posedge clk); #1;
         k++;
      end
      check_eq("t4_drain_idle", idle, 1);
      check_eq("t4_exp0_empty", exp0.size(), 0);
      check_eq("t4_exp1_empty", exp1.size(), 0);

      // Pinned registers: accepted, never written
      drive(1, 7'd0, 128'h55, 1, 7'd20, 128'h66, a0, a1);
      check_eq("t5_acc0", a0, 1);
      check_eq("t5_acc1", a1, 1);
      for (int i = 0; i < 2; i++) begin
         check_eq("t5_ws1", write_signal_1, 0);
         check_eq("t5_ws2", write_signal_2, 0);
         check_eq("t5_idle", idle, 1);
         @(posedge clk); #1;
      end

      // Queue three entries per core, then reset: none may be written afterwards
      for (int c = 0; c < 5; c++)
         drive(1, 7'd11, 128'(c + 32'h300), 1, 7'd11, 128'(c + 32'h400), a0, a1);
      check_eq("t6_queued", idle, 0);
      do_reset();
`ifdef WB_COLLISION_STATS_EN
      check_eq("t6_coll_cleared", collision_count, 0);
`endif
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check_eq("t6_no_write", write_signal_1 | write_signal_2, 0);
      end
      check_eq("t6_idle", idle, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
